neurosync_entrada: RTL
======================

Name: neurosync_entrada

Overview:
Input-conditioning stage directly upstream of the neurosync game core. It takes the four raw player buttons plus the raw jogar and confirma keys and synchronises and debounces them. It then delivers clean single-cycle events to the core: a one-hot jogada with a valid or invalid strobe, and start and confirm pulses. This makes the core immune to bounce, metastability and held or multi-key presses.

Parameters:
DEBOUNCE, 4, consecutive stable cycles required before a synchronised input change is accepted (min 1; must stay below 10 at the 1 kHz system clock)
CW, 3, debounce counter width; must satisfy 2^CW >= DEBOUNCE

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset)
botoes  input  4  raw player buttons, active-high, asynchronous to clock
jogar_raw  input  1  raw start key, active-high
confirma_raw  input  1  raw confirm key, active-high
habilita  input  1  from core: 1 = core is accepting a jogada
jogada  output  4  registered one-hot code of the last accepted button
jogada_valida  output  1  1-cycle strobe: jogada updated with a legal press
jogada_invalida  output  1  1-cycle strobe: more than one button became active simultaneously
jogar_pulso  output  1  1-cycle strobe on debounced rising edge of jogar_raw
confirma_pulso  output  1  1-cycle strobe on debounced rising edge of confirma_raw
db_estado  output  2  FSM state for debug (00 OCIOSO, 01 AGUARDA_SOLTAR, 10 DESCARTA)

Behaviour:
- Reset (reset=0, async): all sync flops, stable bits, counters and strobes go to 0; jogada=4'b0000; FSM=OCIOSO; db_estado=00. Takes effect immediately; may occur mid-press; after release of reset, an input already held high is treated as a new press.
- Each of the 6 raw inputs has its own channel, clocked identically:
  - Synchroniser: 2-flop sync (s1 then s2).
  - Debouncer: stable bit st and counter cnt. If s2==st, cnt<=0. Otherwise cnt increments; on the edge where cnt==DEBOUNCE-1 and s2!=st, st<=s2 and cnt<=0.
  - Consequence: a raw level change present at edge N is reflected in st at edge N+1+DEBOUNCE; glitches shorter than DEBOUNCE cycles never reach st.
- jogar_pulso / confirma_pulso:
  - Registered st & ~st_prev, so high for exactly 1 cycle, asserted at edge N+2+DEBOUNCE.
  - Independent of habilita and of the FSM.
  - Holding a key never repeats the pulse.
- Button FSM, over sb = the 4 stable button bits:
  - OCIOSO, sb==0: stay.
  - OCIOSO, sb!=0 and habilita=1, sb one-hot: jogada<=sb, jogada_valida=1 for one cycle, go to AGUARDA_SOLTAR.
  - OCIOSO, sb!=0 and habilita=1, sb not one-hot: jogada unchanged, jogada_invalida=1 for one cycle, go to AGUARDA_SOLTAR.
  - OCIOSO, sb!=0 and habilita=0: no strobe, go to DESCARTA. A press held across the enable edge never fires late.
  - AGUARDA_SOLTAR / DESCARTA: stay while sb!=0; go to OCIOSO when sb==0. Extra buttons pressed meanwhile are ignored.
- Latency: a single button press first sampled at edge N gives jogada_valida high in the cycle after edge N+2+DEBOUNCE (DEBOUNCE=4: 6 edges).
- Two buttons whose stable bits rise on different cycles: the first one is accepted as valid and the second is ignored.
- jogada_valida and jogada_invalida are mutually exclusive and are never asserted in consecutive cycles.
- jogada holds its value until the next valid press or a reset.

Test Plan:
- Reset, then hold botoes=4'b0001 for 10 cycles -> jogada_valida is 1 for exactly one cycle at DEBOUNCE+2 edges after the first sampling edge; jogada=4'b0001; db_estado 01 while held, 00 after release and settling.
- botoes=4'b0100 held 10 cycles, released 10 cycles, then 4'b0010 held 10 cycles -> two valid strobes, with jogada 4'b0100 then 4'b0010.
- 3-cycle glitch on botoes[3] followed by a 1-cycle glitch on confirma_raw -> no strobes; jogada unchanged.
- botoes=4'b1001 asserted on the same edge -> jogada_invalida pulse; jogada keeps its previous value; no jogada_valida until all buttons are released and re-pressed.
- habilita=0 while 4'b1000 is held, then habilita rises while still held -> no strobe (DESCARTA); after release, press with habilita=1 -> valid strobe.
- jogar_raw and confirma_raw each held 10 cycles -> exactly one jogar_pulso and one confirma_pulso; reset=0 asserted mid-hold clears all outputs immediately.

Source files
------------

// File: rtl/neurosync_entrada.sv
// neurosync_entrada: input-conditioning stage for the neurosync game core.
//
// Six raw keys (four player buttons, jogar, confirma) each pass through a
// 2-flop synchroniser and a counter debouncer. The debounced buttons drive a
// small FSM that emits one clean event per press. The debounced jogar and
// confirma keys produce single-cycle rising-edge pulses.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous active-low reset
//   botoes[3:0]     raw player buttons, active-high, asynchronous
//   jogar_raw       raw start key
//   confirma_raw    raw confirm key
//   habilita        core is accepting a jogada
//   jogada[3:0]     one-hot code of the last accepted button (registered)
//   jogada_valida   1-cycle strobe, legal single-button press accepted
//   jogada_invalida 1-cycle strobe, several buttons became stable together
//   jogar_pulso     1-cycle strobe on debounced rising edge of jogar_raw
//   confirma_pulso  1-cycle strobe on debounced rising edge of confirma_raw
//   db_estado[1:0]  FSM state (00 OCIOSO, 01 AGUARDA_SOLTAR, 10 DESCARTA)

module neurosync_entrada #(
    parameter int DEBOUNCE = 4,
    parameter int CW       = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       jogar_raw,
    input  logic       confirma_raw,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       jogada_valida,
    output logic       jogada_invalida,
    output logic       jogar_pulso,
    output logic       confirma_pulso,
    output logic [1:0] db_estado
);

    typedef enum logic [1:0] {
        OCIOSO         = 2'b00,
        AGUARDA_SOLTAR = 2'b01,
        DESCARTA       = 2'b10
    } estado_t;

    // Channel order: [3:0] buttons, [4] jogar, [5] confirma.
    logic [5:0]    raw;
    logic [5:0]    s1_q, s2_q;
    logic [5:0]    st_q, st_d;
    logic [5:0]    st_prev_q;
    logic [CW-1:0] cnt_q [0:5];
    logic [CW-1:0] cnt_d [0:5];

    logic          jogar_pulso_q, confirma_pulso_q;

    estado_t       estado_q, estado_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          valida_q, valida_d;
    logic          invalida_q, invalida_d;
    logic [3:0]    sb;
    logic          sb_onehot;

    assign raw = {confirma_raw, jogar_raw, botoes};

    // Debounce: a differing synchronised level must persist for DEBOUNCE
    // consecutive edges before the stable bit follows it.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
                    st_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q             <= '0;
            s2_q             <= '0;
            st_q             <= '0;
            st_prev_q        <= '0;
            jogar_pulso_q    <= 1'b0;
            confirma_pulso_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q             <= raw;
            s2_q             <= s1_q;
            st_q             <= st_d;
            st_prev_q        <= st_q;
            jogar_pulso_q    <= st_q[4] & ~st_prev_q[4];
            confirma_pulso_q <= st_q[5] & ~st_prev_q[5];
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sb        = st_q[3:0];
    assign sb_onehot = (sb != 4'b0000) && ((sb & (sb - 4'd1)) == 4'b0000);

    // Only the OCIOSO state can fire a strobe, and every strobe leaves it,
    // so strobes can never land on consecutive cycles.
    always_comb begin
        estado_d   = estado_q;
        jogada_d   = jogada_q;
        valida_d   = 1'b0;
        invalida_d = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (sb != 4'b0000) begin
                    if (!habilita) begin
                        estado_d = DESCARTA;
                    end else if (sb_onehot) begin
                        jogada_d = sb;
                        valida_d = 1'b1;
                        estado_d = AGUARDA_SOLTAR;
                    end else begin
                        invalida_d = 1'b1;
                        estado_d   = AGUARDA_SOLTAR;
                    end
                end
            end
            AGUARDA_SOLTAR, DESCARTA: begin
                if (sb == 4'b0000) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            jogada_q   <= 4'b0000;
            valida_q   <= 1'b0;
            invalida_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            jogada_q   <= jogada_d;
            valida_q   <= valida_d;
            invalida_q <= invalida_d;
        end
    end

    assign jogada          = jogada_q;
    assign jogada_valida   = valida_q;
    assign jogada_invalida = invalida_q;
    assign jogar_pulso     = jogar_pulso_q;
    assign confirma_pulso  = confirma_pulso_q;
    assign db_estado       = estado_q;

endmodule
